// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and its load/store lane steering:
// ls_size encodings, the arbiter FSM state type, byte-enable base patterns and
// an alignment helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_BAD  = 2'b11
  } ls_size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Byte-enable patterns for lane 0; shifted left by the byte offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  // Sign-fill selection for load extension.
  localparam logic EXT_SIGN = 1'b0;
  localparam logic EXT_ZERO = 1'b1;

  // An access is misaligned when it cannot be served as a single lane group.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return a[0];
      SIZE_WORD: return |a;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_lsu_align.sv
// lsu_align: combinational lane steering for load/store accesses.
// Ports:
//   size        ls_size encoding (byte/half/word)
//   addr_lo     byte offset within the word
//   unsigned_ld 1 = zero-extend loads, 0 = sign-extend
//   wdata       LSB-justified store data
//   rdata_raw   raw word returned by memory
//   be          byte enables for the access
//   wdata_rep   store data replicated into every lane
//   rdata_ext   selected load lane, extended to WIDTH
module lsu_align
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       size,
  input  logic [1:0]       addr_lo,
  input  logic             unsigned_ld,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WIDTH-1:0] rdata_raw,
  output logic [3:0]       be,
  output logic [WIDTH-1:0] wdata_rep,
  output logic [WIDTH-1:0] rdata_ext
);

  logic [WIDTH-1:0] shifted;
  logic             fill;

  // Bring the addressed lane down to bit 0.
  assign shifted = rdata_raw >> {addr_lo, 3'b000};

  always_comb begin
    be        = '0;
    wdata_rep = '0;
    rdata_ext = '0;
    fill      = 1'b0;
    case (size)
      SIZE_BYTE: begin
        be        = BE_BYTE << addr_lo;
        wdata_rep = {(WIDTH/8){wdata[7:0]}};
        fill      = (unsigned_ld == EXT_ZERO) ? 1'b0 : shifted[7];
        rdata_ext = {{(WIDTH-8){fill}}, shifted[7:0]};
      end
      SIZE_HALF: begin
        be        = BE_HALF << addr_lo;
        wdata_rep = {(WIDTH/16){wdata[15:0]}};
        fill      = (unsigned_ld == EXT_ZERO) ? 1'b0 : shifted[15];
        rdata_ext = {{(WIDTH-16){fill}}, shifted[15:0]};
      end
      SIZE_WORD: begin
        be        = BE_WORD;
        wdata_rep = wdata;
        rdata_ext = shifted;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an instruction-fetch port and a load/store port onto
// a single memory port. Load/store wins unless fetch has lost STARVE_MAX times
// in a row. One access is outstanding at a time; misaligned load/store accesses
// are answered with an error without touching memory.
// Ports:
//   clk, rst                           clock, asynchronous active-low reset
//   if_req/if_addr/if_gnt              fetch request, word address, grant
//   if_rvalid/if_rdata                 fetch response
//   ls_req/ls_we/ls_addr/ls_wdata      load/store request
//   ls_size/ls_unsigned                access size, zero-extend loads
//   ls_gnt/ls_rvalid/ls_err/ls_rdata   load/store grant and response
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  memory request
//   mem_rdata/mem_ready                memory read data and completion
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int STARVE_MAX = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  output logic [WIDTH-1:0] if_rdata,
  input  logic             ls_req,
  input  logic             ls_we,
  input  logic [WIDTH-1:0] ls_addr,
  input  logic [WIDTH-1:0] ls_wdata,
  input  logic [1:0]       ls_size,
  input  logic             ls_unsigned,
  output logic             ls_gnt,
  output logic             ls_rvalid,
  output logic             ls_err,
  output logic [WIDTH-1:0] ls_rdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       mem_be,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ready
);

  localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WIDTH-1:0] ADDR_MASK = {{(WIDTH-2){1'b1}}, 2'b00};

  arb_state_e       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             ls_win;
  logic             cur_is_ls;
  logic             cur_we;
  logic [1:0]       cur_size;
  logic [1:0]       cur_lo;
  logic             cur_uns;
  logic             busy;
  logic [1:0]       al_size;
  logic [1:0]       al_lo;
  logic             al_uns;
  logic [3:0]       al_be;
  logic [WIDTH-1:0] al_wdata;
  logic [WIDTH-1:0] al_rdata;

  assign busy    = (state == ST_BUSY);
  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
  assign ls_win  = ls_req && !(if_req && starved);

  always_comb begin
    if_gnt = 1'b0;
    ls_gnt = 1'b0;
    if (!busy) begin
      ls_gnt = ls_win;
      if_gnt = if_req && !ls_win;
    end
  end

  // The aligner serves the live request while idle (store steering, byte
  // enables) and the captured transaction while busy (load extension), so a
  // single instance covers both directions.
  assign al_size = busy ? cur_size : ls_size;
  assign al_lo   = busy ? cur_lo   : ls_addr[1:0];
  assign al_uns  = busy ? cur_uns  : ls_unsigned;

  lsu_align #(.WIDTH(WIDTH)) u_align (
    .size       (al_size),
    .addr_lo    (al_lo),
    .unsigned_ld(al_uns),
    .wdata      (ls_wdata),
    .rdata_raw  (mem_rdata),
    .be         (al_be),
    .wdata_rep  (al_wdata),
    .rdata_ext  (al_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      starve_cnt <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rvalid  <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_err     <= 1'b0;
      if_rdata   <= '0;
      ls_rdata   <= '0;
      cur_is_ls  <= 1'b0;
      cur_we     <= 1'b0;
      cur_size   <= '0;
      cur_lo     <= '0;
      cur_uns    <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_err    <= 1'b0;

      if (if_gnt) begin
        starve_cnt <= '0;
      end else if (ls_gnt && if_req && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end

      case (state)
        ST_IDLE: begin
          if (ls_gnt) begin
            if (misaligned(ls_size, ls_addr[1:0])) begin
              // Answered locally; memory never sees the access.
              ls_rvalid <= 1'b1;
              ls_err    <= 1'b1;
              ls_rdata  <= '0;
            end else begin
              state     <= ST_BUSY;
              mem_req   <= 1'b1;
              mem_we    <= ls_we;
              mem_addr  <= ls_addr & ADDR_MASK;
              mem_be    <= al_be;
              mem_wdata <= ls_we ? al_wdata : '0;
              cur_is_ls <= 1'b1;
              cur_we    <= ls_we;
              cur_size  <= ls_size;
              cur_lo    <= ls_addr[1:0];
              cur_uns   <= ls_unsigned;
            end
          end else if (if_gnt) begin
            state     <= ST_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr & ADDR_MASK;
            mem_be    <= BE_WORD;
            mem_wdata <= '0;
            cur_is_ls <= 1'b0;
            cur_we    <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (cur_is_ls) begin
              ls_rvalid <= 1'b1;
              ls_rdata  <= cur_we ? '0 : al_rdata;
            end else begin
              if_rvalid <= 1'b1;
              if_rdata  <= mem_rdata;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a response scoreboard. Inputs change 1
// time unit after the rising edge; outputs are sampled 3 units after it.
module tb_mem_arbiter;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic [WIDTH-1:0] if_rdata;
  logic             ls_req;
  logic             ls_we;
  logic [WIDTH-1:0] ls_addr;
  logic [WIDTH-1:0] ls_wdata;
  logic [1:0]       ls_size;
  logic             ls_unsigned;
  logic             ls_gnt;
  logic             ls_rvalid;
  logic             ls_err;
  logic [WIDTH-1:0] ls_rdata;
  logic             mem_req;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [3:0]       mem_be;
  logic [WIDTH-1:0] mem_rdata;
  logic             mem_ready;

  mem_arbiter #(.WIDTH(WIDTH), .STARVE_MAX(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_size    (ls_size),
    .ls_unsigned(ls_unsigned),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_err     (ls_err),
    .ls_rdata   (ls_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_ls;
    bit          err;
    logic [31:0] rdata;
  } resp_t;

  resp_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input bit is_ls, input bit err, input logic [31:0] rd);
    resp_t e;
    e.is_ls = is_ls;
    e.err   = err;
    e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Waits (bounded) for a response strobe and compares it with the oldest
  // expected entry.
  task automatic expect_resp(input string tag, input int max_wait);
    resp_t e;
    int    w;
    w = 0;
    while (!(if_rvalid || ls_rvalid) && w < max_wait) begin
      cyc();
      settle();
      w++;
    end
    check({tag, "_rvalid"}, 32'(if_rvalid | ls_rvalid), 32'd1);
    check({tag, "_excl"}, 32'(if_rvalid & ls_rvalid), 32'd0);
    check({tag, "_qsize"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_port"}, 32'(ls_rvalid), 32'(e.is_ls));
      check({tag, "_err"}, 32'(ls_err), 32'(e.err));
      check({tag, "_rdata"}, e.is_ls ? ls_rdata : if_rdata, e.rdata);
    end
  endtask

  // Called in the grant cycle: checks the memory request at grant+1, completes
  // it immediately and checks the response at grant+2.
  task automatic access(input string tag, input logic [3:0] be, input logic [31:0] addr,
                        input logic we, input logic [31:0] wdata, input logic [31:0] rd);
    cyc();
    if_req = 1'b0;
    ls_req = 1'b0;
    settle();
    check({tag, "_mem_req"}, 32'(mem_req), 32'd1);
    check({tag, "_mem_be"}, 32'(mem_be), 32'(be));
    check({tag, "_mem_addr"}, mem_addr, addr);
    check({tag, "_mem_we"}, 32'(mem_we), 32'(we));
    check({tag, "_mem_wdata"}, mem_wdata, wdata);
    mem_ready = 1'b1;
    mem_rdata = rd;
    cyc();
    mem_ready = 1'b0;
    settle();
    expect_resp(tag, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    ls_size = 2'b10; ls_unsigned = 1'b0;
    mem_rdata = '0; mem_ready = 1'b0;

    // Reset state
    cyc(); settle();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_be", 32'(mem_be), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    check("rst_ls_err", 32'(ls_err), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ls_rdata", ls_rdata, 32'd0);

    cyc();
    rst = 1'b1;

    // Simultaneous requests: ls first, fetch granted in the response cycle
    cyc();
    if_req = 1'b1; if_addr = 32'h43;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h10;
    settle();
    check("t1_ls_gnt", 32'(ls_gnt), 32'd1);
    check("t1_if_gnt", 32'(if_gnt), 32'd0);
    push_exp(1'b1, 1'b0, 32'h1234_5678);
    cyc();
    ls_req = 1'b0;
    settle();
    check("t1_busy_mem_req", 32'(mem_req), 32'd1);
    check("t1_busy_mem_addr", mem_addr, 32'h10);
    check("t1_busy_mem_be", 32'(mem_be), 32'hf);
    check("t1_busy_if_gnt", 32'(if_gnt), 32'd0);
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    cyc();
    mem_ready = 1'b0;
    settle();
    expect_resp("t1_ls", 0);
    check("t1_if_gnt2", 32'(if_gnt), 32'd1);
    check("t1_ls_gnt2", 32'(ls_gnt), 32'd0);
    push_exp(1'b0, 1'b0, 32'hCAFE_BABE);
    access("t1_if", 4'hf, 32'h40, 1'b0, 32'd0, 32'hCAFE_BABE);

    // Signed byte load from the top lane
    cyc();
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h103; ls_unsigned = 1'b0;
    settle();
    check("t2_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b0, 32'hFFFF_FF80);
    access("t2_lb", 4'b1000, 32'h100, 1'b0, 32'd0, 32'h80FF_0000);
    check("t2_if_rdata_hold", if_rdata, 32'hCAFE_BABE);

    // Unsigned half load from the upper half
    cyc();
    ls_req = 1'b1; ls_size = 2'b01; ls_addr = 32'h102; ls_unsigned = 1'b1;
    settle();
    check("t2b_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b0, 32'h0000_80FF);
    access("t2b_lhu", 4'b1100, 32'h100, 1'b0, 32'd0, 32'h80FF_0000);

    // Half store: data replicated into both halves, response data zero
    cyc();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b01; ls_addr = 32'h202;
    ls_wdata = 32'h0000_BEEF; ls_unsigned = 1'b0;
    settle();
    check("t3_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b0, 32'd0);
    access("t3_sh", 4'b1100, 32'h200, 1'b1, 32'hBEEF_BEEF, 32'hDEAD_DEAD);

    // Byte store: data replicated into all four lanes
    cyc();
    ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h301;
    ls_wdata = 32'h1234_56A5;
    settle();
    check("t3b_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b0, 32'd0);
    access("t3b_sb", 4'b0010, 32'h300, 1'b1, 32'hA5A5_A5A5, 32'h5555_5555);

    // Misaligned word: error at grant+1, no memory access
    cyc();
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h001;
    settle();
    check("t4_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b1, 32'd0);
    cyc();
    ls_req = 1'b0;
    settle();
    check("t4_mem_req_g1", 32'(mem_req), 32'd0);
    expect_resp("t4_lw_mis", 0);
    cyc(); settle();
    check("t4_mem_req_g2", 32'(mem_req), 32'd0);
    check("t4_rvalid_pulse", 32'(ls_rvalid), 32'd0);

    // Reserved size encoding is an error even when aligned
    cyc();
    ls_req = 1'b1; ls_size = 2'b11; ls_addr = 32'h008;
    settle();
    check("t4b_ls_gnt", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b1, 32'd0);
    cyc();
    ls_req = 1'b0;
    settle();
    check("t4b_mem_req", 32'(mem_req), 32'd0);
    expect_resp("t4b_size11", 0);

    // Starvation: three ls wins, then fetch on the fourth arbitration
    cyc();
    if_req = 1'b1; if_addr = 32'h80;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h20;
    settle();
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t5_ls_gnt%0d", k), 32'(ls_gnt), 32'(k < 3));
      check($sformatf("t5_if_gnt%0d", k), 32'(if_gnt), 32'(k == 3));
      push_exp(k < 3, 1'b0, 32'h1000_0000 + 32'(k));
      cyc();
      mem_ready = 1'b1;
      mem_rdata = 32'h1000_0000 + 32'(k);
      if (k == 3) begin
        if_req = 1'b0;
        ls_req = 1'b0;
      end
      settle();
      check($sformatf("t5_mem_req%0d", k), 32'(mem_req), 32'd1);
      cyc();
      mem_ready = 1'b0;
      settle();
      expect_resp($sformatf("t5_resp%0d", k), 0);
    end

    // Reset while busy: access abandoned, grant right after release
    cyc();
    if_req = 1'b1; if_addr = 32'h44;
    settle();
    check("t6_if_gnt", 32'(if_gnt), 32'd1);
    cyc();
    if_req = 1'b0;
    settle();
    check("t6_busy_mem_req", 32'(mem_req), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_async_mem_req", 32'(mem_req), 32'd0);
    check("t6_async_mem_be", 32'(mem_be), 32'd0);
    check("t6_async_mem_addr", mem_addr, 32'd0);
    cyc(); settle();
    check("t6_rst_if_rvalid", 32'(if_rvalid), 32'd0);
    check("t6_rst_ls_rvalid", 32'(ls_rvalid), 32'd0);
    cyc();
    rst = 1'b1;
    ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b10; ls_addr = 32'h50;
    settle();
    check("t6_if_rvalid_after", 32'(if_rvalid), 32'd0);
    check("t6_ls_gnt_after", 32'(ls_gnt), 32'd1);
    push_exp(1'b1, 1'b0, 32'h0BAD_F00D);
    access("t6_lw", 4'hf, 32'h50, 1'b0, 32'd0, 32'h0BAD_F00D);

    check("end_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
